relobi_xbar_cfg: RTL and testbench

Configuration and scrubbing controller for the reliable OBI crossbar. It owns the three TMR copies of the crossbar address map, the per-subordinate-port default-index settings, and drives them directly into the crossbar's map inputs. A background FSM periodically majority-votes every entry and rewrites any divergent copy. The block also keeps saturating counters of the crossbar's two fault lines.

---
 rtl/relobi_xbar_cfg_pkg.sv | 11 +
 rtl/relobi_cfg_voter.sv | 13 +
 rtl/relobi_xbar_cfg.sv | 172 +++++++++++++++++
 tb/tb_relobi_xbar_cfg.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/relobi_xbar_cfg_pkg.sv
// relobi_xbar_cfg_pkg: shared FSM states, config select encoding and helpers for the crossbar config block.
package relobi_xbar_cfg_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, FIX = 2'd2} scrub_state_e;
  localparam logic [1:0] SEL_START = 2'd0;
  localparam logic [1:0] SEL_END = 2'd1;
  localparam logic [1:0] SEL_IDX = 2'd2;
  localparam logic [1:0] SEL_DEF = 2'd3;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/relobi_cfg_voter.sv
// relobi_cfg_voter: bitwise 2-of-3 majority with a copy-mismatch flag.
module relobi_cfg_voter #(
  parameter int Width = 32
) (
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  input  logic [Width-1:0] c,
  output logic [Width-1:0] y,
  output logic             mismatch
);
  assign y = (a & b) | (a & c) | (b & c);
  assign mismatch = (a != b) || (a != c);
endmodule

// File: rtl/relobi_xbar_cfg.sv
// relobi_xbar_cfg: TMR address-map/default-index store for the reliable OBI crossbar with background scrubbing and fault counters.
module relobi_xbar_cfg
  import relobi_xbar_cfg_pkg::*;
#(
  parameter int NumSbrPorts = 2,
  parameter int NumMgrPorts = 2,
  parameter int NumAddrRules = 4,
  parameter int AddrWidth = 32,
  parameter int ScrubInterval = 1024,
  parameter int CntWidth = 16,
  localparam int IdxW = max2(1, $clog2(NumMgrPorts)),
  localparam int CfgIdxW = $clog2(max2(NumAddrRules, NumSbrPorts)),
  localparam int RuleW = IdxW + 2 * AddrWidth
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic                                       cfg_req_i,
  output logic                                       cfg_gnt_o,
  input  logic                                       cfg_we_i,
  input  logic [1:0]                                 cfg_sel_i,
  input  logic [CfgIdxW-1:0]                         cfg_idx_i,
  input  logic [AddrWidth-1:0]                       cfg_wdata_i,
  input  logic                                       cfg_inj_i,
  input  logic [1:0]                                 cfg_copy_i,
  output logic                                       cfg_rvalid_o,
  output logic [AddrWidth-1:0]                       cfg_rdata_o,
  output logic [2:0][NumAddrRules-1:0][RuleW-1:0]    addr_map_o,
  output logic [2:0][NumSbrPorts-1:0]                en_default_idx_o,
  output logic [2:0][NumSbrPorts-1:0][IdxW-1:0]      default_idx_o,
  input  logic [1:0]                                 xbar_fault_i,
  input  logic                                       clr_cnt_i,
  output logic [1:0][CntWidth-1:0]                   fault_cnt_o,
  output logic [CntWidth-1:0]                        corr_cnt_o,
  output logic                                       scrub_busy_o
);
  localparam int NumEntries = NumAddrRules + NumSbrPorts;
  localparam int EntW = $clog2(NumEntries);
  localparam int TmrW = $clog2(ScrubInterval + 1);
  typedef struct packed {
    logic [IdxW-1:0]      idx;
    logic [AddrWidth-1:0] start_addr;
    logic [AddrWidth-1:0] end_addr;
  } rule_t;
  rule_t [2:0][NumAddrRules-1:0]         map_q;
  logic [2:0][NumSbrPorts-1:0]           en_q;
  logic [2:0][NumSbrPorts-1:0][IdxW-1:0] didx_q;
  scrub_state_e                          state_q;
  logic [TmrW-1:0]                       timer_q;
  logic [EntW-1:0]                       entry_q;
  logic [1:0][CntWidth-1:0]              fault_q;
  logic [CntWidth-1:0]                   corr_q;
  logic                                  rvalid_q;
  logic [AddrWidth-1:0]                  rdata_q;
  logic gnt, rule_ok, def_ok, last, ent_mm;
  logic [2:0][AddrWidth-1:0] rd_c;
  logic [AddrWidth-1:0]      rd_v;
  logic [2:0][RuleW-1:0]     ent_c;
  logic [RuleW-1:0]          ent_v;

  assign gnt = cfg_req_i && !rst_i && state_q != FIX;
  assign rule_ok = cfg_sel_i != SEL_DEF && 32'(cfg_idx_i) < NumAddrRules;
  assign def_ok = cfg_sel_i == SEL_DEF && 32'(cfg_idx_i) < NumSbrPorts;
  assign last = entry_q == EntW'(NumEntries - 1);
  assign cfg_gnt_o = gnt;
  assign cfg_rvalid_o = rvalid_q;
  assign cfg_rdata_o = rdata_q;
  assign addr_map_o = map_q;
  assign en_default_idx_o = en_q;
  assign default_idx_o = didx_q;
  assign fault_cnt_o = fault_q;
  assign corr_cnt_o = corr_q;
  assign scrub_busy_o = state_q != IDLE;

  // Per-copy view of the addressed field (read) and of the scrub entry; default entries pack as {idx, en}.
  always_comb begin
    rd_c = '0;
    ent_c = '0;
    for (int c = 0; c < 3; c++) begin
      for (int r = 0; r < NumAddrRules; r++) begin
        if (rule_ok && cfg_idx_i == CfgIdxW'(r))
          rd_c[c] = cfg_sel_i == SEL_START ? map_q[c][r].start_addr :
                    cfg_sel_i == SEL_END   ? map_q[c][r].end_addr : AddrWidth'(map_q[c][r].idx);
        if (entry_q == EntW'(r)) ent_c[c] = map_q[c][r];
      end
      for (int p = 0; p < NumSbrPorts; p++) begin
        if (def_ok && cfg_idx_i == CfgIdxW'(p)) rd_c[c] = AddrWidth'({didx_q[c][p], en_q[c][p]});
        if (entry_q == EntW'(NumAddrRules + p)) ent_c[c] = RuleW'({didx_q[c][p], en_q[c][p]});
      end
    end
  end

  relobi_cfg_voter #(.Width(RuleW)) u_scan_vote (
    .a(ent_c[0]), .b(ent_c[1]), .c(ent_c[2]), .y(ent_v), .mismatch(ent_mm)
  );

  relobi_cfg_voter #(.Width(AddrWidth)) u_rd_vote (
    .a(rd_c[0]), .b(rd_c[1]), .c(rd_c[2]), .y(rd_v), .mismatch()
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      map_q <= '0;
      en_q <= '0;
      didx_q <= '0;
      state_q <= IDLE;
      timer_q <= TmrW'(ScrubInterval);
      entry_q <= '0;
      fault_q <= '0;
      corr_q <= '0;
      rvalid_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      rvalid_q <= gnt && !cfg_we_i;
      if (gnt && !cfg_we_i) rdata_q <= rd_v;
      // Config writes and FIX never coincide: the grant is withheld in FIX.
      for (int c = 0; c < 3; c++) begin
        if (gnt && cfg_we_i && (!cfg_inj_i || cfg_copy_i == 2'(c))) begin
          for (int r = 0; r < NumAddrRules; r++)
            if (rule_ok && cfg_idx_i == CfgIdxW'(r)) begin
              if (cfg_sel_i == SEL_START) map_q[c][r].start_addr <= cfg_wdata_i;
              else if (cfg_sel_i == SEL_END) map_q[c][r].end_addr <= cfg_wdata_i;
              else map_q[c][r].idx <= cfg_wdata_i[IdxW-1:0];
            end
          for (int p = 0; p < NumSbrPorts; p++)
            if (def_ok && cfg_idx_i == CfgIdxW'(p)) begin
              en_q[c][p] <= cfg_wdata_i[0];
              didx_q[c][p] <= cfg_wdata_i[IdxW:1];
            end
        end
        if (state_q == FIX) begin
          for (int r = 0; r < NumAddrRules; r++)
            if (entry_q == EntW'(r)) map_q[c][r] <= ent_v;
          for (int p = 0; p < NumSbrPorts; p++)
            if (entry_q == EntW'(NumAddrRules + p)) begin
              en_q[c][p] <= ent_v[0];
              didx_q[c][p] <= ent_v[IdxW:1];
            end
        end
      end
      for (int k = 0; k < 2; k++)
        fault_q[k] <= clr_cnt_i ? '0 : fault_q[k] + CntWidth'(xbar_fault_i[k] && !(&fault_q[k]));
      corr_q <= clr_cnt_i ? '0 : corr_q + CntWidth'(state_q == FIX && !(&corr_q));
      case (state_q)
        IDLE: begin
          if (timer_q <= TmrW'(1)) begin
            state_q <= SCAN;
            entry_q <= '0;
          end else timer_q <= timer_q - TmrW'(1);
        end
        SCAN: begin
          if (!gnt) begin
            if (ent_mm) state_q <= FIX;
            else if (last) begin
              state_q <= IDLE;
              timer_q <= TmrW'(ScrubInterval);
            end else entry_q <= entry_q + EntW'(1);
          end
        end
        FIX: begin
          if (last) begin
            state_q <= IDLE;
            timer_q <= TmrW'(ScrubInterval);
          end else begin
            state_q <= SCAN;
            entry_q <= entry_q + EntW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_relobi_xbar_cfg.sv
// tb_relobi_xbar_cfg: scoreboard bench for the crossbar config/scrub controller.
module tb_relobi_xbar_cfg;
  localparam int NSP = 2, NMP = 2, NAR = 3, AW = 32, SI = 16, CW = 3, NE = NAR + NSP;
  logic clk = 1'b0;
  logic rst, req, gnt, we, inj, rvalid, busy, clr;
  logic [1:0] sel, copy, xf, idx;
  logic [AW-1:0] wdata, rdata;
  logic [2:0][NAR-1:0][64:0] amap;
  logic [2:0][NSP-1:0] en_d;
  logic [2:0][NSP-1:0][0:0] d_idx;
  logic [1:0][CW-1:0] fcnt;
  logic [CW-1:0] ccnt;
  logic [64:0] em [NAR];
  logic [31:0] rq [$];
  bit rv_exp = 1'b0;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  relobi_xbar_cfg #(
    .NumSbrPorts(NSP), .NumMgrPorts(NMP), .NumAddrRules(NAR),
    .AddrWidth(AW), .ScrubInterval(SI), .CntWidth(CW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .cfg_req_i(req), .cfg_gnt_o(gnt), .cfg_we_i(we),
    .cfg_sel_i(sel), .cfg_idx_i(idx), .cfg_wdata_i(wdata), .cfg_inj_i(inj),
    .cfg_copy_i(copy), .cfg_rvalid_o(rvalid), .cfg_rdata_o(rdata),
    .addr_map_o(amap), .en_default_idx_o(en_d), .default_idx_o(d_idx),
    .xbar_fault_i(xf), .clr_cnt_i(clr), .fault_cnt_o(fcnt), .corr_cnt_o(ccnt),
    .scrub_busy_o(busy)
  );

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // Read scoreboard: every granted read must produce exactly one rvalid on the next cycle.
  always @(negedge clk) begin
    if (rv_exp || rvalid) begin
      check("rvalid", rvalid, rv_exp);
      if (rvalid) begin
        if (rq.size() == 0) check("rq_underflow", 1, 0);
        else check("rdata", rdata, rq.pop_front());
      end
      rv_exp = 1'b0;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk) begin
      req = 1'b0;
      inj = 1'b0;
    end
  endtask

  task automatic acc(input logic w, input logic [1:0] s, input logic [1:0] i, input logic [31:0] d,
                     input logic ij, input logic [1:0] cp, input logic [31:0] e, output logic g);
    @(negedge clk);
    req = 1'b1; we = w; sel = s; idx = i; wdata = d; inj = ij; copy = cp;
    #1 g = gnt;
    @(posedge clk);
    if (g && !w) begin
      rq.push_back(e);
      rv_exp = 1'b1;
    end
  endtask

  task automatic wr(input logic [1:0] s, input logic [1:0] i, input logic [31:0] d);
    logic g;
    acc(1'b1, s, i, d, 1'b0, 2'd0, 32'd0, g);
    check("wr_gnt", g, 1);
    idle(1);
  endtask

  task automatic rd(input logic [1:0] s, input logic [1:0] i, input logic [31:0] e);
    logic g;
    acc(1'b0, s, i, 32'd0, 1'b0, 2'd0, e, g);
    check("rd_gnt", g, 1);
    idle(1);
  endtask

  task automatic inject(input logic [1:0] s, input logic [1:0] i, input logic [31:0] d, input logic [1:0] cp);
    logic g;
    acc(1'b1, s, i, d, 1'b1, cp, 32'd0, g);
    check("inj_gnt", g, 1);
    idle(1);
  endtask

  task automatic chk_map(input string tag);
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < NAR; r++) check(tag, amap[c][r], em[r]);
  endtask

  task automatic wait_busy(input logic v, input int max, input string tag);
    int k = 0;
    @(negedge clk);
    while (busy !== v && k < max) begin
      @(negedge clk);
      k++;
    end
    check(tag, busy, v);
  endtask

  task automatic do_rst();
    @(negedge clk);
    rst = 1'b1;
    req = 1'b0;
    inj = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r < NAR; r++) em[r] = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1);
  end

  initial begin
    int nb, ng;
    logic g;
    rst = 1'b1; req = 1'b1; we = 1'b1; sel = 2'd0; idx = 2'd0; wdata = '0;
    inj = 1'b0; copy = 2'd0; xf = 2'b00; clr = 1'b0;
    for (int r = 0; r < NAR; r++) em[r] = '0;
    repeat (2) @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_corr", ccnt, 0);
    check("rst_fault", fcnt, 0);
    chk_map("rst_map");
    req = 1'b0;
    rst = 1'b0;
    // write and read back rule 1
    wr(2'd0, 2'd1, 32'h1000_0000);
    for (int c = 0; c < 3; c++) check("wr_start_copy", amap[c][1], {1'b0, 32'h1000_0000, 32'h0});
    wr(2'd1, 2'd1, 32'h2000_0000);
    wr(2'd2, 2'd1, 32'h1);
    em[1] = {1'b1, 32'h1000_0000, 32'h2000_0000};
    chk_map("wr_map");
    rd(2'd0, 2'd1, 32'h1000_0000);
    rd(2'd1, 2'd1, 32'h2000_0000);
    rd(2'd2, 2'd1, 32'h1);
    // out-of-range indices
    wr(2'd0, 2'd3, 32'hFFFF_FFFF);
    chk_map("oor_map");
    rd(2'd0, 2'd3, 32'h0);
    wr(2'd3, 2'd2, 32'h3);
    check("oor_def_en", en_d, 0);
    rd(2'd3, 2'd2, 32'h0);
    // default entry
    wr(2'd3, 2'd1, 32'h3);
    for (int c = 0; c < 3; c++) begin
      check("def_en", en_d[c], 2'b10);
      check("def_idx", d_idx[c][1], 1);
    end
    rd(2'd3, 2'd1, 32'h3);
    // injection with copy 3 is dropped
    inject(2'd0, 2'd0, 32'hABCD, 2'd3);
    chk_map("inj3_map");
    // scrub correction
    do_rst();
    inject(2'd0, 2'd0, 32'hDEAD_0000, 2'd2);
    check("inj_copy2", amap[2][0], {1'b0, 32'hDEAD_0000, 32'h0});
    check("inj_copy0", amap[0][0], 0);
    rd(2'd0, 2'd0, 32'h0);
    nb = 0;
    repeat (SI + NE + 2) @(negedge clk) nb += busy ? 1 : 0;
    check("scrub_busy_cycles", nb, NE + 1);
    check("scrub_corr", ccnt, 1);
    chk_map("scrub_map");
    rd(2'd0, 2'd0, 32'h0);
    // clean scan stalled by continuous writes
    do_rst();
    wait_busy(1'b1, SI + 4, "stall_start");
    ng = 0;
    for (int i = 0; i < 10; i++) begin
      acc(1'b1, 2'd1, 2'd2, 32'(i), 1'b0, 2'd0, 32'd0, g);
      ng += g ? 1 : 0;
    end
    idle(1);
    check("stall_gnts", ng, 10);
    check("stall_busy", busy, 1);
    wait_busy(1'b0, NE + 2, "stall_done");
    check("stall_corr", ccnt, 0);
    rd(2'd1, 2'd2, 32'd9);
    // FIX drops the grant for one cycle
    inject(2'd0, 2'd0, 32'h55, 2'd0);
    wait_busy(1'b1, SI + 4, "fix_start");
    ng = 0;
    for (int i = 0; i < 8; i++) begin
      acc(1'b1, 2'd1, 2'd2, 32'(100 + i), 1'b0, 2'd0, 32'd0, g);
      ng += g ? 0 : 1;
    end
    idle(1);
    check("fix_gnt_drops", ng, 1);
    check("fix_corr", ccnt, 1);
    wait_busy(1'b0, NE + 2, "fix_done");
    for (int c = 0; c < 3; c++) check("fix_rule0", amap[c][0], 0);
    rd(2'd1, 2'd2, 32'd107);
    // fault counters
    @(negedge clk) xf = 2'b01;
    repeat (5) @(negedge clk);
    xf = 2'b00;
    check("fault0_5", fcnt[0], 5);
    check("fault1_0", fcnt[1], 0);
    xf = 2'b01;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    xf = 2'b00;
    check("fault_clr", fcnt[0], 0);
    xf = 2'b11;
    repeat (10) @(negedge clk);
    xf = 2'b00;
    check("fault0_sat", fcnt[0], 7);
    check("fault1_sat", fcnt[1], 7);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("corr_clr", ccnt, 0);
    // reset in the middle of FIX
    do_rst();
    wr(2'd1, 2'd2, 32'h42);
    rd(2'd1, 2'd2, 32'h42);
    inject(2'd0, 2'd0, 32'h77, 2'd0);
    xf = 2'b01;
    wait_busy(1'b1, SI + 4, "midfix_start");
    @(negedge clk);
    req = 1'b1;
    we = 1'b0;
    #1 check("midfix_gnt", gnt, 0);
    check("midfix_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midfix_rst_busy", busy, 0);
    check("midfix_rst_gnt", gnt, 0);
    check("midfix_rst_rvalid", rvalid, 0);
    check("midfix_rst_rdata", rdata, 0);
    check("midfix_rst_corr", ccnt, 0);
    check("midfix_rst_fault", fcnt, 0);
    check("midfix_rst_en", en_d, 0);
    for (int r = 0; r < NAR; r++) em[r] = '0;
    chk_map("midfix_rst_map");
    rst = 1'b0;
    req = 1'b0;
    xf = 2'b00;
    idle(2);
    check("rq_empty", rq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
